// File: rtl/dmem_responder_pkg.sv
// Shared constants and FSM encodings for the data-memory responder.
// Imported by the bank and the responder top.
package dmem_responder_pkg;

  localparam int          REG_BUS_D    = 32;
  localparam logic        CHIP_ENABLE  = 1'b1;
  localparam logic        WRITE_ENABLE = 1'b1;
  localparam logic        RST_EN       = 1'b0;
  localparam logic [31:0] ZERO_WORD    = 32'h0;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_responder_bank.sv
// Word array with per-byte write enables and a registered read port.
// The read register can be cleared so out-of-range loads return zero.
module dmem_bank
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic                 clk_i,
  input  logic                 n_rst_i,
  input  logic                 we_i,
  input  logic [3:0]           sel_i,
  input  logic [ADDR_W-1:0]    waddr_i,
  input  logic [REG_BUS_D-1:0] wdata_i,
  input  logic                 re_i,
  input  logic                 clr_i,
  input  logic [ADDR_W-1:0]    raddr_i,
  output logic [REG_BUS_D-1:0] rdata_o
);

  logic [REG_BUS_D-1:0] mem_q [DEPTH];
  logic [REG_BUS_D-1:0] rdata_q;

  // No reset on the array: contents survive a pipeline reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_i[b]) begin
          mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (n_rst_i == RST_EN) begin
      rdata_q <= ZERO_WORD;
    end else if (clr_i) begin
      rdata_q <= ZERO_WORD;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the LSU interface: posted stores, multi-cycle loads
// with a pipeline stall request, and an out-of-range error pulse.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH    = 1024,
  parameter int ADDR_W   = 10,
  parameter int READ_LAT = 2
) (
  input  logic                 clk_i,
  input  logic                 n_rst_i,
  input  logic                 mem_ce_i,
  input  logic                 mem_we_i,
  input  logic [31:0]          mem_a_i,
  input  logic [3:0]           mem_sel_i,
  input  logic [REG_BUS_D-1:0] mem_data_i,
  output logic [REG_BUS_D-1:0] mem_data_o,
  output logic                 stall_req_o,
  output logic                 access_err_o
);

  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  dmem_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              oor_q, oor_d;

  logic              oor;
  logic [ADDR_W-1:0] idx;
  logic              wr_en;
  logic              rd_en;
  logic              rd_clr;
  logic              stall;
  logic              err;
  logic              unused_ok;

  assign oor       = |mem_a_i[31:ADDR_W+2];
  assign idx       = mem_a_i[ADDR_W+1:2];
  assign unused_ok = ^mem_a_i[1:0];

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (n_rst_i == RST_EN) begin
      state_q <= DMEM_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      oor_q   <= oor_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    oor_d   = oor_q;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    rd_clr  = 1'b0;
    stall   = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      DMEM_IDLE: begin
        if (mem_ce_i == CHIP_ENABLE) begin
          err = oor;
          if (mem_we_i == WRITE_ENABLE) begin
            wr_en = ~oor;
          end else begin
            stall   = 1'b1;
            idx_d   = idx;
            oor_d   = oor;
            cnt_d   = CNT_W'(READ_LAT - 1);
            state_d = DMEM_WAIT;
          end
        end
      end
      DMEM_WAIT: begin
        stall = 1'b1;
        if (cnt_q == '0) begin
          rd_en   = ~oor_q;
          rd_clr  = oor_q;
          state_d = DMEM_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DMEM_RESP: begin
        state_d = DMEM_IDLE;
      end
      default: begin
        state_d = DMEM_IDLE;
      end
    endcase
  end

  // Combinational outputs are forced low while reset is held.
  assign stall_req_o  = stall & (n_rst_i != RST_EN);
  assign access_err_o = err & (n_rst_i != RST_EN);

  dmem_bank #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clk_i   (clk_i),
    .n_rst_i (n_rst_i),
    .we_i    (wr_en),
    .sel_i   (mem_sel_i),
    .waddr_i (idx),
    .wdata_i (mem_data_i),
    .re_i    (rd_en),
    .clr_i   (rd_clr),
    .raddr_i (idx_q),
    .rdata_o (mem_data_o)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: expected load data is queued when a
// load is issued and popped when the response cycle is reached.
module tb_dmem_responder;

  localparam int DEPTH    = 1024;
  localparam int ADDR_W   = 10;
  localparam int READ_LAT = 2;

  logic        clk;
  logic        n_rst;
  logic        ce;
  logic        we;
  logic [31:0] a;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        err;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] sb_q [$];

  dmem_responder #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .READ_LAT (READ_LAT)
  ) dut (
    .clk_i        (clk),
    .n_rst_i      (n_rst),
    .mem_ce_i     (ce),
    .mem_we_i     (we),
    .mem_a_i      (a),
    .mem_sel_i    (sel),
    .mem_data_i   (wdata),
    .mem_data_o   (rdata),
    .stall_req_o  (stall),
    .access_err_o (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] d,
                          input logic [3:0] s, input logic exp_err);
    ce = 1'b1; we = 1'b1; a = addr; sel = s; wdata = d;
    #1;
    chk("st_stall", {31'b0, stall}, 32'd0);
    chk("st_err", {31'b0, err}, {31'b0, exp_err});
    next_cyc();
    ce = 1'b0; we = 1'b0;
  endtask

  // resp_st: drive an (ignored) store during the response cycle.
  task automatic do_load(input logic [31:0] addr, input logic [31:0] exp,
                         input logic exp_err, input logic resp_st);
    logic [31:0] e;
    ce = 1'b1; we = 1'b0; a = addr; sel = 4'hF;
    sb_q.push_back(exp);
    #1;
    chk("ld_acc_stall", {31'b0, stall}, 32'd1);
    chk("ld_acc_err", {31'b0, err}, {31'b0, exp_err});
    next_cyc();
    for (int k = 0; k < READ_LAT; k++) begin
      chk("ld_wait_stall", {31'b0, stall}, 32'd1);
      chk("ld_wait_err", {31'b0, err}, 32'd0);
      next_cyc();
    end
    if (resp_st) begin
      ce = 1'b1; we = 1'b1; sel = 4'hF; wdata = 32'h0;
    end else begin
      ce = 1'b0;
    end
    #1;
    chk("ld_resp_stall", {31'b0, stall}, 32'd0);
    chk("ld_resp_err", {31'b0, err}, 32'd0);
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk("ld_data", rdata, e);
    end
    next_cyc();
    ce = 1'b0; we = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0; ce = 1'b0; we = 1'b0;
    a = '0; sel = '0; wdata = '0;
    #1;
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_data", rdata, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    next_cyc();

    // Store then load of the same word on the next cycle.
    do_store(32'h10, 32'hDEADBEEF, 4'b1111, 1'b0);
    do_load(32'h10, 32'hDEADBEEF, 1'b0, 1'b0);

    // Reset in the middle of a load.
    ce = 1'b1; we = 1'b0; a = 32'h10;
    #1;
    chk("mid_acc_stall", {31'b0, stall}, 32'd1);
    next_cyc();
    n_rst = 1'b0;
    #1;
    chk("mid_rst_stall", {31'b0, stall}, 32'd0);
    chk("mid_rst_data", rdata, 32'd0);
    ce = 1'b0;
    next_cyc();
    n_rst = 1'b1;
    next_cyc();
    chk("post_rst_idle", {31'b0, stall}, 32'd0);
    chk("post_rst_data", rdata, 32'd0);
    do_load(32'h10, 32'hDEADBEEF, 1'b0, 1'b0);

    // Byte and half-word lanes.
    do_store(32'h20, 32'h11223344, 4'b1111, 1'b0);
    do_store(32'h22, 32'hAAAAAAAA, 4'b0100, 1'b0);
    do_store(32'h20, 32'h55665566, 4'b0011, 1'b0);
    do_load(32'h20, 32'h11AA5566, 1'b0, 1'b0);

    // Data holds across stores.
    do_store(32'h24, 32'h77777777, 4'b1111, 1'b0);
    chk("hold_data", rdata, 32'h11AA5566);

    // Back-to-back loads.
    do_store(32'h0, 32'h01020304, 4'b1111, 1'b0);
    do_store(32'h4, 32'hA5A55A5A, 4'b1111, 1'b0);
    do_load(32'h0, 32'h01020304, 1'b0, 1'b0);
    do_load(32'h4, 32'hA5A55A5A, 1'b0, 1'b0);

    // Out of range: store must not alias onto word 0.
    do_store(DEPTH * 4, 32'hFFFFFFFF, 4'b1111, 1'b1);
    do_load(32'h0, 32'h01020304, 1'b0, 1'b0);
    do_load(DEPTH * 4, 32'h0, 1'b1, 1'b0);
    do_load(32'h3FFC + (DEPTH * 4), 32'h0, 1'b1, 1'b0);

    // Top in-range word and a misaligned address.
    do_store(DEPTH * 4 - 4, 32'hBEEF0001, 4'b1111, 1'b0);
    do_load(DEPTH * 4 - 1, 32'hBEEF0001, 1'b0, 1'b0);

    // sel=0000 writes nothing; a request in RESP is ignored.
    do_store(32'h30, 32'hCAFEF00D, 4'b1111, 1'b0);
    do_store(32'h30, 32'h12345678, 4'b0000, 1'b0);
    do_load(32'h30, 32'hCAFEF00D, 1'b0, 1'b1);
    do_load(32'h30, 32'hCAFEF00D, 1'b0, 1'b0);

    chk("sb_drained", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
